// File: rtl/mdio_pkg.sv
// Shared types and field widths for the Clause 22 MDIO responder.
package mdio_pkg;

  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PRE_W   = 6;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA
  } state_t;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with rising-edge detect.
module mdio_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= d;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise_c = sync & ~sync_d;

endmodule

// File: rtl/mdio_slave.sv
// Clause 22 MDIO responder: decodes read/write frames for PHY_ADDR and
// exposes them on a single-cycle register port.
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd1,
  parameter int unsigned        PRE_MIN  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mdc,
  input  logic               mdio_i,
  output logic               mdio_o,
  output logic               mdio_oe,
  output logic [REGAD_W-1:0] reg_addr,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_we,
  output logic               reg_re,
  input  logic [DATA_W-1:0]  reg_rdata
);

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [PRE_W-1:0]    pre, pre_n;
  logic [DATA_W-1:0]   shreg, shreg_n;
  logic [DATA_W-1:0]   bits;
  logic                is_read, is_read_n;
  logic                re_d;
  logic                mdio_o_n, mdio_oe_n;
  logic [REGAD_W-1:0]  reg_addr_n;
  logic [DATA_W-1:0]   reg_wdata_n;
  logic                reg_we_n, reg_re_n;
  logic                tick;
  logic                mdio_meta, mdio_s;
  logic                pre_done;

  mdio_sync_edge u_mdc_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (mdc),
    .rise_c (tick)
  );

  // mdio only needs resynchronizing; its edges carry no meaning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdio_meta <= 1'b0;
      mdio_s    <= 1'b0;
    end else begin
      mdio_meta <= mdio_i;
      mdio_s    <= mdio_meta;
    end
  end

  assign bits     = {shreg[DATA_W-2:0], mdio_s};
  assign pre_done = (pre == PRE_W'(PRE_MIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      pre       <= '0;
      shreg     <= '0;
      is_read   <= 1'b0;
      re_d      <= 1'b0;
      mdio_o    <= 1'b0;
      mdio_oe   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pre       <= pre_n;
      shreg     <= shreg_n;
      is_read   <= is_read_n;
      re_d      <= reg_re;
      mdio_o    <= mdio_o_n;
      mdio_oe   <= mdio_oe_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_we    <= reg_we_n;
      reg_re    <= reg_re_n;
    end
  end

  // Frame decoder; all bit-level work happens in the tick clk
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pre_n       = pre;
    shreg_n     = shreg;
    is_read_n   = is_read;
    mdio_o_n    = mdio_o;
    mdio_oe_n   = mdio_oe;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_we_n    = 1'b0;
    reg_re_n    = 1'b0;

    // register file answers the clk after the read strobe
    if (re_d) shreg_n = reg_rdata;

    if (tick) begin
      cnt_n = cnt + CNT_W'(1);
      unique case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (mdio_s) begin
            if (!pre_done) pre_n = pre + PRE_W'(1);
          end else begin
            pre_n = '0;
            if (pre_done) state_n = S_ST;
          end
        end
        S_ST: begin
          cnt_n   = '0;
          state_n = mdio_s ? S_OP : S_IDLE;
        end
        S_OP: begin
          shreg_n = bits;
          if (cnt == CNT_W'(1)) begin
            cnt_n     = '0;
            is_read_n = (bits[1:0] == OP_READ);
            state_n   = (bits[1:0] == OP_READ || bits[1:0] == OP_WRITE) ? S_PHYAD : S_IDLE;
          end
        end
        S_PHYAD: begin
          shreg_n = bits;
          if (cnt == CNT_W'(PHYAD_W - 1)) begin
            cnt_n   = '0;
            state_n = (bits[PHYAD_W-1:0] == PHY_ADDR) ? S_REGAD : S_IDLE;
          end
        end
        S_REGAD: begin
          shreg_n = bits;
          if (cnt == CNT_W'(REGAD_W - 1)) begin
            cnt_n      = '0;
            reg_addr_n = bits[REGAD_W-1:0];
            reg_re_n   = is_read;
            state_n    = S_TA;
          end
        end
        S_TA: begin
          if (cnt == '0) begin
            if (is_read) begin
              mdio_oe_n = 1'b1;
              mdio_o_n  = 1'b0;
            end
          end else begin
            cnt_n   = '0;
            state_n = is_read ? S_RDATA : S_WDATA;
            if (is_read) begin
              mdio_o_n = shreg[DATA_W-1];
              shreg_n  = {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
        S_WDATA: begin
          shreg_n = bits;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt_n       = '0;
            reg_wdata_n = bits;
            reg_we_n    = 1'b1;
            state_n     = S_IDLE;
          end
        end
        S_RDATA: begin
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt_n     = '0;
            mdio_oe_n = 1'b0;
            mdio_o_n  = 1'b0;
            state_n   = S_IDLE;
          end else begin
            mdio_o_n = shreg[DATA_W-1];
            shreg_n  = {shreg[DATA_W-2:0], 1'b0};
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdio_slave.md
# mdio_slave

Clause 22 MDIO management responder, the target end of the bit-banged MDC/MDIO bus the MCU drives through GPIO. It decodes read and write frames addressed to its configured PHY address and exposes them on a simple single-cycle register port. It drives MDIO only during read turnaround and data. The board uses it to emulate PHY management registers, in the same spirit as the NVM emulator.

## Interface
Parameters:
- PHY_ADDR, 5'd1: PHY address this responder answers to.
- PRE_MIN, 32: consecutive 1 bits required before ST. Range 0–32; 0 means preamble suppression.

Ports:
- clk, input, 1: system clock. All logic is on posedge clk.
- rst_n, input, 1: reset, asynchronous and active-low.
- mdc, input, 1: management clock, asynchronous to clk.
- mdio_i, input, 1: MDIO pad input, asynchronous to clk.
- mdio_o, output, 1: MDIO output value.
- mdio_oe, output, 1: MDIO output enable. The pad is `mdio_oe ? mdio_o : 1'bz`.
- reg_addr, output, 5: REGAD of the current frame.
- reg_wdata, output, 16: write data. Valid while reg_we=1.
- reg_we, output, 1: one-clk write strobe.
- reg_re, output, 1: one-clk read strobe.
- reg_rdata, input, 16: read data. Must be valid on the clk after reg_re.

## Operation
- mdc and mdio_i each pass through a 2-flop synchronizer. An MDC rising edge ("tick") is detected from the synchronized mdc.
- All bit sampling uses the synchronized mdio value at a tick. All output changes happen in the tick clk.
- State machine: IDLE → ST → OP → PHYAD → REGAD → TA → WDATA or RDATA → IDLE.
- IDLE:
  - Count consecutive 1s, saturating at PRE_MIN.
  - A 0 seen with count ≥ PRE_MIN → ST.
  - A 0 seen with count < PRE_MIN clears the count.
- ST: expect 1. A 0 → IDLE.
- OP: 2 bits, MSB first.
  - 10 = read, 01 = write.
  - 00 or 11 → IDLE, with no strobe and no drive.
- PHYAD: 5 bits, MSB first. A mismatch against PHY_ADDR → IDLE after the 5th bit, with no strobe and no drive.
- REGAD: 5 bits, MSB first, loaded into reg_addr on the 5th bit. For a read, reg_re pulses in the same clk.
- Read path:
  - reg_rdata is captured into the shift register the clk after reg_re.
  - TA bit 1: mdio_oe stays 0.
  - At the tick sampling TA bit 1: mdio_oe=1, mdio_o=0 (TA bit 2).
  - At the tick sampling TA bit 2: mdio_o=D15.
  - At each subsequent tick: shift out the next bit, down to D0.
  - At the tick sampling D0: mdio_oe=0, mdio_o=0 → IDLE.
- Write path:
  - TA bits are sampled and ignored.
  - WDATA collects 16 bits, MSB first.
  - On the 16th tick: load reg_wdata, pulse reg_we for 1 clk → IDLE.
- Preamble is recognized only in IDLE. The preamble count restarts at 0 on every entry to IDLE.
- Every frame, including aborted ones, returns to IDLE. A new frame is accepted only after PRE_MIN fresh 1s.

## Timing
- Reset values: mdio_o=0, mdio_oe=0, reg_we=0, reg_re=0, reg_addr=0, reg_wdata=0. State is IDLE and the preamble count is 0.
- Reset is asynchronous. Asserting it mid-frame releases MDIO immediately.
- Pin-to-action latency: 3 clk from an mdc pin rising edge to its tick (2 sync + 1 edge detect). Drive changes and strobes land in the tick clk.
- MDC high and low phases must each be ≥ 4 clk. At 125 MHz clk this is met by MDC ≤ 12.5 MHz, far above the 2.5 MHz MDC used.
- The data-valid window seen by the master (drive change ≤ 4 clk after MDC rise) satisfies the 802.3 300 ns clock-to-output limit.
- reg_re and reg_we are never asserted in the same clk. Each is exactly 1 clk wide, once per matching frame.

## Structure
- Shared package mdio_pkg holds:
  - the state enum;
  - OP_READ=2'b10 and OP_WRITE=2'b01;
  - field widths (PHYAD_W=5, REGAD_W=5, DATA_W=16).
- Sub-module mdio_sync_edge: 2-flop synchronizer with rising-edge detect. Instantiated for mdc; the mdio path uses the synchronizer only.
- Top level holds the FSM, bit counter, shift register and the register port.

## Test plan
- Write: 32×1, ST 01, OP 01, PHYAD=PHY_ADDR, REGAD=0x04, TA 10, data 0xA5C3. Expect one reg_we pulse with reg_addr=0x04, reg_wdata=0xA5C3. mdio_oe stays 0 throughout.
- Read: same preamble, OP 10, REGAD=0x02, reg_rdata=0x0141. Expect one reg_re pulse. The master samples 0 at TA2, then 0x0141 MSB first. mdio_oe drops at the tick sampling D0.
- Address mismatch: PHYAD=PHY_ADDR^1, both read and write. Expect no strobes and mdio_oe=0. A following correct frame with 32 preamble bits is serviced.
- Short preamble: 31×1 then a valid write frame. Expect it ignored. With PRE_MIN=0, back-to-back frames without preamble are both serviced.
- Reset mid-read: assert rst_n=0 during RDATA bit 8. Expect mdio_oe=0 within the same clk. After release, a fresh read frame returns correct data.
